rc4_key_search: RTL

Parametrised RC4 brute-force key search engine, successor to the fixed-key decode top level. For each candidate key in a caller-supplied range it runs S-array init, key-scheduling shuffle and keystream decode against an external encrypted ROM, writes the plaintext to an external decrypted RAM, and checks every byte. It stops on the first key whose plaintext is entirely lowercase letters or space. It owns the S-memory port itself, so no separate task multiplexer is needed.

---
 rtl/rc4_pkg.sv | 39 +++
 rtl/rc4_key_counter.sv | 35 +++
 rtl/rc4_key_search.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 brute-force key search engine.
package rc4_pkg;

  localparam int S_SIZE = 256;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_A_LO  = 8'h61;
  localparam logic [7:0] CHAR_Z_LO  = 8'h7a;

  // One state per cycle of every phase: the shuffle and decode loops are
  // unrolled into their per-iteration micro-steps.
  typedef enum logic [4:0] {
    ST_IDLE,
    ST_INIT,
    SH_RD_I,
    SH_WAIT_I,
    SH_RD_J,
    SH_WAIT_J,
    SH_WR_I,
    SH_WR_J,
    DE_RD_I,
    DE_WAIT_I,
    DE_RD_J,
    DE_WAIT_J,
    DE_WR_I,
    DE_WR_J,
    DE_RD_F,
    DE_WAIT_F,
    DE_OUT,
    ST_NEXT,
    ST_DONE
  } state_t;

  // A plaintext byte is acceptable only if it is a lowercase letter or space.
  function automatic logic is_plain_char(input logic [7:0] b);
    return ((b >= CHAR_A_LO) && (b <= CHAR_Z_LO)) || (b == CHAR_SPACE);
  endfunction

endpackage

// File: rtl/rc4_key_counter.sv
// Candidate key register: loads the range start, steps by one, and reports
// when the current key is the last one of the range.
module rc4_key_counter #(
  parameter int KW = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          inc,
  input  logic [KW-1:0] key_lo,
  input  logic [KW-1:0] key_hi,
  output logic [KW-1:0] current_key,
  output logic          last
);

  logic [KW-1:0] key_hi_q;

  // Capture the range on load, then count up one key per request.
  always_ff @(posedge clk) begin
    if (reset) begin
      current_key <= '0;
      key_hi_q    <= '0;
    end else if (load) begin
      current_key <= key_lo;
      key_hi_q    <= key_hi;
    end else if (inc) begin
      current_key <= current_key + 1'b1;
    end
  end

  // The key only ever counts up from key_lo, so it can exceed key_hi only
  // when the range was given reversed; that case ends after the first key.
  assign last = (current_key >= key_hi_q);

endmodule

// File: rtl/rc4_key_search.sv
// RC4 brute-force key search: for each candidate key, initialise S, run the
// key schedule, decode the message into the plaintext RAM and stop on the
// first key whose plaintext is all lowercase letters or space.
module rc4_key_search
  import rc4_pkg::*;
#(
  parameter  int KEY_BYTES = 3,
  parameter  int MSG_LEN   = 32,
  localparam int KW        = 8 * KEY_BYTES
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [KW-1:0] key_lo,
  input  logic [KW-1:0] key_hi,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic [KW-1:0] found_key,
  output logic [KW-1:0] current_key,
  output logic [7:0]    s_address,
  output logic [7:0]    s_data,
  output logic          s_write_enable,
  input  logic [7:0]    s_q,
  output logic [7:0]    encrypted_address,
  input  logic [7:0]    encrypted_q,
  output logic [7:0]    decrypted_address,
  output logic [7:0]    decrypted_data,
  output logic          decrypted_write_enable
);

  localparam logic [7:0] I_LAST = 8'(S_SIZE - 1);
  localparam logic [7:0] K_LAST = 8'(MSG_LEN - 1);

  state_t     state, state_next;
  logic [7:0] i, j, k, si, sj;
  logic [7:0] key_byte;
  logic [7:0] plain;
  logic       plain_ok;
  logic       key_last;
  logic       key_load;
  logic       key_inc;

  assign key_load = (state == ST_IDLE) && start;
  assign key_inc  = (state == ST_NEXT) && !key_last;

  rc4_key_counter #(.KW(KW)) u_key_counter (
    .clk         (clk),
    .reset       (reset),
    .load        (key_load),
    .inc         (key_inc),
    .key_lo      (key_lo),
    .key_hi      (key_hi),
    .current_key (current_key),
    .last        (key_last)
  );

  assign plain    = s_q ^ encrypted_q;
  assign plain_ok = is_plain_char(plain);

  // Select key byte (i mod KEY_BYTES), most significant byte first.
  always_comb begin
    key_byte = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if ((int'(i) % KEY_BYTES) == b) key_byte = current_key[KW-1-8*b -: 8];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic walking the per-cycle micro-steps of each phase.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_INIT;
      ST_INIT:   if (i == I_LAST) state_next = SH_RD_I;
      SH_RD_I:   state_next = SH_WAIT_I;
      SH_WAIT_I: state_next = SH_RD_J;
      SH_RD_J:   state_next = SH_WAIT_J;
      SH_WAIT_J: state_next = SH_WR_I;
      SH_WR_I:   state_next = SH_WR_J;
      SH_WR_J:   state_next = (i == I_LAST) ? DE_RD_I : SH_RD_I;
      DE_RD_I:   state_next = DE_WAIT_I;
      DE_WAIT_I: state_next = DE_RD_J;
      DE_RD_J:   state_next = DE_WAIT_J;
      DE_WAIT_J: state_next = DE_WR_I;
      DE_WR_I:   state_next = DE_WR_J;
      DE_WR_J:   state_next = DE_RD_F;
      DE_RD_F:   state_next = DE_WAIT_F;
      DE_WAIT_F: state_next = DE_OUT;
      DE_OUT: begin
        if (!plain_ok)        state_next = ST_NEXT;
        else if (k == K_LAST) state_next = ST_DONE;
        else                  state_next = DE_RD_I;
      end
      ST_NEXT:   state_next = key_last ? ST_DONE : ST_INIT;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Memory port and status outputs, decoded purely from the current state.
  always_comb begin
    busy                   = (state != ST_IDLE) && (state != ST_DONE);
    done                   = (state == ST_DONE);
    s_address              = '0;
    s_data                 = '0;
    s_write_enable         = 1'b0;
    encrypted_address      = '0;
    decrypted_address      = '0;
    decrypted_data         = '0;
    decrypted_write_enable = 1'b0;
    case (state)
      ST_INIT: begin
        s_address      = i;
        s_data         = i;
        s_write_enable = 1'b1;
      end
      SH_RD_I, SH_WAIT_I, SH_RD_J: s_address = i;
      SH_WAIT_J:                   s_address = j;
      SH_WR_I, DE_WR_I: begin
        s_address      = i;
        s_data         = s_q;
        s_write_enable = 1'b1;
      end
      SH_WR_J, DE_WR_J: begin
        s_address      = j;
        s_data         = si;
        s_write_enable = 1'b1;
      end
      default: ;
    endcase
    case (state)
      DE_RD_I:            s_address = i + 8'd1;
      DE_WAIT_I, DE_RD_J: s_address = i;
      DE_WAIT_J:          s_address = j;
      DE_RD_F, DE_WAIT_F: s_address = si + sj;
      default: ;
    endcase
    case (state)
      DE_RD_I, DE_WAIT_I, DE_RD_J, DE_WAIT_J, DE_WR_I, DE_WR_J,
      DE_RD_F, DE_WAIT_F:
        encrypted_address = k;
      DE_OUT: begin
        encrypted_address      = k;
        decrypted_address      = k;
        decrypted_data         = plain;
        decrypted_write_enable = 1'b1;
      end
      default: ;
    endcase
  end

  // i/j/k counters and the two swap holding registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      i  <= '0;
      j  <= '0;
      k  <= '0;
      si <= '0;
      sj <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          i <= '0;
          j <= '0;
          k <= '0;
        end
        ST_INIT: begin
          i <= i + 8'd1;
          j <= '0;
        end
        SH_RD_J: begin
          si <= s_q;
          j  <= j + s_q + key_byte;
        end
        SH_WR_J: begin
          i <= i + 8'd1;
          if (i == I_LAST) begin
            j <= '0;
            k <= '0;
          end
        end
        DE_RD_I: i <= i + 8'd1;
        DE_RD_J: begin
          si <= s_q;
          j  <= j + s_q;
        end
        DE_WR_I: sj <= s_q;
        DE_OUT:  k  <= k + 8'd1;
        ST_NEXT: begin
          i <= '0;
          j <= '0;
          k <= '0;
        end
        default: ;
      endcase
    end
  end

  // Search result: cleared on a new start, set when a whole message decodes.
  always_ff @(posedge clk) begin
    if (reset) begin
      found     <= 1'b0;
      found_key <= '0;
    end else if (key_load) begin
      found     <= 1'b0;
      found_key <= '0;
    end else if ((state == DE_OUT) && plain_ok && (k == K_LAST)) begin
      found     <= 1'b1;
      found_key <= current_key;
    end
  end

endmodule
